// File: rtl/dodge_engine_param.sv
// Game-logic core for the falling-object dodge game: player, hazards, bonus,
// lives/score bookkeeping and a one-cycle registered column read port for the LED scan mux.
module dodge_engine_param #(
  parameter int          COLS     = 8,
  parameter int          ROWS     = 8,
  parameter int          N_HAZ    = 3,
  parameter int          LIVES    = 3,
  parameter int          PLAYER_H = 2,
  parameter int          GUARD    = 4,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic                    CLK,
  input  logic                    clear_n,
  input  logic                    tick,
  input  logic                    start,
  input  logic                    btn_left,
  input  logic                    btn_right,
  input  logic                    btn_up,
  input  logic                    btn_down,
  input  logic [$clog2(COLS)-1:0] scan_col,
  output logic [ROWS-1:0]         haz_row,
  output logic [ROWS-1:0]         bonus_row,
  output logic [ROWS-1:0]         player_row,
  output logic [2:0]              lives,
  output logic [15:0]             score,
  output logic [1:0]              state,
  output logic                    game_over
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int GW = (GUARD < 1) ? 1 : $clog2(GUARD + 1);
  localparam logic [CW-1:0] PX_INIT = CW'(COLS / 2 - 1);
  localparam logic [CW-1:0] PX_MAX  = CW'(COLS - 1);
  localparam logic [RW-1:0] PY_MAX  = RW'(ROWS - PLAYER_H);
  localparam logic [RW-1:0] ROW_END = RW'(ROWS - 1);

  typedef enum logic [1:0] {S_IDLE = 2'b00, S_PLAY = 2'b01, S_OVER = 2'b10} state_t;

  state_t          state_q, state_d;
  logic [2:0]      lives_q, lives_d;
  logic [15:0]     score_q, score_d;
  logic [GW-1:0]   guard_q, guard_d;
  logic [CW-1:0]   px_q, px_d;
  logic [RW-1:0]   py_q, py_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [N_HAZ-1:0] haz_act_q, haz_act_d;
  logic [3:0]      haz_col_q [N_HAZ];
  logic [3:0]      haz_col_d [N_HAZ];
  logic [RW-1:0]   haz_rw_q  [N_HAZ];
  logic [RW-1:0]   haz_rw_d  [N_HAZ];
  logic            bon_act_q, bon_act_d;
  logic [3:0]      bon_col_q, bon_col_d;
  logic [RW-1:0]   bon_rw_q, bon_rw_d;

  logic [3:0]       col_pick;
  logic [N_HAZ-1:0] haz_hit;
  logic             bon_hit, row0_busy, spawned;
  logic [ROWS-1:0]  haz_bits, bon_bits, pl_bits;

  // Control state: asynchronously cleared
  always_ff @(posedge CLK or negedge clear_n) begin
    if (!clear_n) begin
      state_q    <= S_IDLE;
      lives_q    <= 3'(LIVES);
      score_q    <= '0;
      guard_q    <= '0;
      px_q       <= PX_INIT;
      py_q       <= PY_MAX;
      lfsr_q     <= SEED;
      haz_act_q  <= '0;
      bon_act_q  <= 1'b0;
      haz_row    <= '1;
      bonus_row  <= '1;
      player_row <= '1;
    end else begin
      state_q    <= state_d;
      lives_q    <= lives_d;
      score_q    <= score_d;
      guard_q    <= guard_d;
      px_q       <= px_d;
      py_q       <= py_d;
      lfsr_q     <= lfsr_d;
      haz_act_q  <= haz_act_d;
      bon_act_q  <= bon_act_d;
      haz_row    <= haz_bits;
      bonus_row  <= bon_bits;
      player_row <= pl_bits;
    end
  end

  // Object positions are only meaningful while the matching active bit is set
  always_ff @(posedge CLK) begin
    haz_col_q <= haz_col_d;
    haz_rw_q  <= haz_rw_d;
    bon_col_q <= bon_col_d;
    bon_rw_q  <= bon_rw_d;
  end

  always_comb begin
    lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    col_pick  = lfsr_q[3:0];
    if (int'(lfsr_q[3:0]) >= COLS) col_pick = lfsr_q[3:0] - 4'(COLS);
    state_d   = state_q;
    lives_d   = lives_q;
    score_d   = score_q;
    guard_d   = guard_q;
    px_d      = px_q;
    py_d      = py_q;
    haz_act_d = haz_act_q;
    haz_col_d = haz_col_q;
    haz_rw_d  = haz_rw_q;
    bon_act_d = bon_act_q;
    bon_col_d = bon_col_q;
    bon_rw_d  = bon_rw_q;
    haz_hit   = '0;
    bon_hit   = 1'b0;
    row0_busy = 1'b0;
    spawned   = 1'b0;
    if (tick) begin
      unique case (state_q)
        S_IDLE: if (start) state_d = S_PLAY;
        S_OVER: if (start) begin
          state_d   = S_PLAY;
          lives_d   = 3'(LIVES);
          score_d   = '0;
          guard_d   = '0;
          px_d      = PX_INIT;
          py_d      = PY_MAX;
          haz_act_d = '0;
          bon_act_d = 1'b0;
        end
        S_PLAY: begin
          if (btn_right && !btn_left && px_q != PX_MAX) px_d = px_q + CW'(1);
          else if (btn_left && !btn_right && px_q != '0) px_d = px_q - CW'(1);
          if (btn_up && !btn_down && py_q != '0) py_d = py_q - RW'(1);
          else if (btn_down && !btn_up && py_q != PY_MAX) py_d = py_q + RW'(1);

          for (int i = 0; i < N_HAZ; i++) begin
            if (haz_act_q[i]) begin
              if (haz_rw_q[i] == ROW_END) begin
                haz_act_d[i] = 1'b0;
                if (score_d != 16'hFFFF) score_d = score_d + 16'd1;
              end else begin
                haz_rw_d[i] = haz_rw_q[i] + RW'(1);
              end
            end
          end
          if (bon_act_q) begin
            if (bon_rw_q == ROW_END) bon_act_d = 1'b0;
            else bon_rw_d = bon_rw_q + RW'(1);
          end

          for (int i = 0; i < N_HAZ; i++)
            if (haz_act_d[i] && haz_rw_d[i] == '0) row0_busy = 1'b1;
          if (bon_act_d && bon_rw_d == '0) row0_busy = 1'b1;
          if (!row0_busy) begin
            if (!bon_act_d && lfsr_q[15:12] == 4'd0) begin
              bon_act_d = 1'b1;
              bon_col_d = col_pick;
              bon_rw_d  = '0;
            end else begin
              for (int i = 0; i < N_HAZ; i++) begin
                if (!spawned && !haz_act_d[i]) begin
                  haz_act_d[i] = 1'b1;
                  haz_col_d[i] = col_pick;
                  haz_rw_d[i]  = '0;
                  spawned      = 1'b1;
                end
              end
            end
          end

          // Collisions use the post-move player and post-advance objects
          for (int i = 0; i < N_HAZ; i++)
            haz_hit[i] = haz_act_d[i] && int'(haz_col_d[i]) == int'(px_d) &&
                         int'(haz_rw_d[i]) >= int'(py_d) &&
                         int'(haz_rw_d[i]) < int'(py_d) + PLAYER_H;
          bon_hit = bon_act_d && int'(bon_col_d) == int'(px_d) &&
                    int'(bon_rw_d) >= int'(py_d) && int'(bon_rw_d) < int'(py_d) + PLAYER_H;
          if (haz_hit != '0 && guard_q == '0) begin
            lives_d   = lives_q - 3'd1;
            guard_d   = GW'(GUARD);
            haz_act_d = haz_act_d & ~haz_hit;
          end else if (guard_q != '0) begin
            guard_d = guard_q - GW'(1);
          end
          if (bon_hit) begin
            bon_act_d = 1'b0;
            if (lives_d < 3'(LIVES)) lives_d = lives_d + 3'd1;
          end
          if (lives_d == 3'd0) state_d = S_OVER;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Column read port: active-low bitmaps of the requested column
  always_comb begin
    haz_bits = '1;
    bon_bits = '1;
    pl_bits  = '1;
    if (int'(scan_col) < COLS) begin
      for (int i = 0; i < N_HAZ; i++)
        if (haz_act_q[i] && int'(haz_col_q[i]) == int'(scan_col)) haz_bits[haz_rw_q[i]] = 1'b0;
      if (bon_act_q && int'(bon_col_q) == int'(scan_col)) bon_bits[bon_rw_q] = 1'b0;
      if (state_q != S_OVER && int'(px_q) == int'(scan_col))
        for (int r = 0; r < ROWS; r++)
          if (r >= int'(py_q) && r < int'(py_q) + PLAYER_H) pl_bits[r] = 1'b0;
    end
  end

  assign lives     = lives_q;
  assign score     = score_q;
  assign state     = state_q;
  assign game_over = (state_q == S_OVER);

endmodule

// File: doc/dodge_engine_param.md
Name: dodge_engine_param

Overview:
- Parametrised game-logic core for the falling-object dodge game. It holds the player, N_HAZ hazard objects and one bonus object on a COLS x ROWS grid, plus lives, score and game state.
- Sits between the button/tick dividers and the LED-matrix scan mux. The scan mux requests a column index and receives active-low row bitmaps per colour plane.
- Generalises the fixed 8x8, 3-hazard, 3-life design. Adds an LFSR spawner, a post-hit guard window, saturating lives and score, and a registered scan read port.

Parameters:
- COLS, 8, grid columns (2..16)
- ROWS, 8, grid rows (4..16); row 0 is the top
- N_HAZ, 3, hazard slots (1..8)
- LIVES, 3, starting and maximum lives (1..7)
- PLAYER_H, 2, player height in rows (1..ROWS-1)
- GUARD, 4, ticks after a hit during which hazard collisions are ignored
- SEED, 16'hACE1, LFSR reset value (must be nonzero)

Ports:
- CLK  in  1  system clock
- clear_n  in  1  asynchronous active-low reset
- tick  in  1  one-CLK pulse; advances one game step
- start  in  1  level; sampled on tick
- btn_left, btn_right, btn_up, btn_down  in  1 each  level; sampled on tick
- scan_col  in  clog2(COLS)  column requested by the display mux
- haz_row  out  ROWS  active-low hazard bitmap of scan_col
- bonus_row  out  ROWS  active-low bonus bitmap of scan_col
- player_row  out  ROWS  active-low player bitmap of scan_col
- lives  out  3  remaining lives
- score  out  16  hazards dodged
- state  out  2  00 IDLE, 01 PLAY, 10 OVER
- game_over  out  1  high when state is OVER

Behaviour:
Reset (clear_n low, asynchronous):
- state=IDLE, lives=LIVES, score=0, all objects inactive, guard=0.
- px=COLS/2-1, py=ROWS-PLAYER_H.
- lfsr=SEED.
- All row outputs 1s.
- Releasing reset mid-game always restarts from IDLE.

LFSR:
- 16-bit Galois, mask 16'hB400. Steps every CLK, independent of tick.
- Column pick: c=lfsr[3:0] mod 16; if c>=COLS then c-=COLS.

State transitions (only on cycles where tick=1):
- IDLE: start=1 -> PLAY.
- PLAY: lives reaches 0 -> OVER.
- OVER: start=1 -> reinitialise all reset fields except lfsr, then enter PLAY.

PLAY tick sequence (all in one tick, in this order):
1. Move player:
   - Horizontal: right only -> px+1 unless px==COLS-1. Left only -> px-1 unless px==0. Both pressed -> no horizontal move.
   - Vertical: up -> py-1 unless py==0. Down -> py+1 unless py==ROWS-PLAYER_H. Both pressed -> no vertical move.
2. Advance objects:
   - Every active object does row+1.
   - An object at row ROWS-1 despawns instead.
   - Each despawning hazard adds score+1, saturating at 16'hFFFF. A despawning bonus adds nothing.
3. Spawn: at most one spawn per tick, and only if no active object is in row 0 after step 2.
   - If the bonus is inactive and lfsr[15:12]==0: spawn the bonus at row 0, column c.
   - Otherwise: spawn into the lowest-index inactive hazard slot at row 0, column c.
4. Collision, using post-move positions. An object hits if col==px and py<=row<=py+PLAYER_H-1.
   - Hazard hits with guard==0: lives-1 (one life max per tick, regardless of hit count), guard=GUARD, all hitting hazards despawn with no score.
   - Hazard hits with guard>0: ignored; the hazards continue falling.
   - Bonus hit: lives+1, saturating at LIVES; the bonus despawns. Evaluated after the hazard decrement in the same tick.
   - guard decrements by 1 on every tick where guard>0 and no new hit occurs.

IDLE and OVER:
- Objects, player, score and lives are frozen.
- In OVER, player_row reads all 1s (player blanked).

Scan read port:
- Outputs are registered with one CLK latency from scan_col.
- Bit r=0 when the corresponding object or player occupies (scan_col, r).
- Overlapping objects of the same plane OR together, i.e. AND of the active-low bits.
- scan_col>=COLS returns all 1s.

Test Plan:
- Reset, then start+tick -> state=01, lives=3, score=0. Player pixels present only in column 3, rows 6-7: player_row=8'b00111111 at scan_col=3.
- btn_right held for 6 ticks from px=3 -> px stops at 7. Left and right held together for 1 tick -> px unchanged.
- Force lfsr so a hazard spawns in column 3 with the player parked there. After 6 ticks -> lives=2, guard=4. A second hazard reaching the player within 4 ticks -> lives stays 2.
- Hazard falls from row 0 in a column the player is not in. On the 8th tick it despawns -> score=1, the slot is freed, and the next spawn uses slot 0.
- Run until lives reaches 0 -> state=10, game_over=1, objects frozen, player_row=8'hFF. Then start+tick -> state=01, lives=3, score=0.
- Bonus hit at lives=3 -> lives stays 3. Bonus hit at lives=1 -> lives=2. Assert clear_n mid-fall -> all outputs take reset values immediately, without waiting for a CLK edge.
